ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  pipeline clock; all state captures on the falling edge, matching upstream pipeline registers.
REQ-003 reset  in  1  asynchronous, active-low; clears all state.
REQ-004 stall  in  1  hold all EX/MEM state this cycle.
REQ-005 flush  in  1  replace the incoming instruction with a bubble.
REQ-006 valid_EX, memToReg_EX, memWrite_EX, memRead_EX, branchLink_EX, RegWrite_EX, set_flags_EX  in  1 each  EX-stage control bits.
REQ-007 targetReg_EX  in  5  destination register.
REQ-008 alu_result, rd2_EX, pc_plus4_EX  in  64 each  ALU result, store data, link value.
REQ-009 alu_flags  in  4  NZCV from the ALU, bit3=N ... bit0=V.
REQ-010 valid_MEM, memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM  out  1 each  registered control.
REQ-011 targetReg_MEM  out  5; alu_result_MEM, rd2_MEM, pc_plus4_MEM  out  64 each  registered data.
REQ-012 flags  out  4  architectural NZCV register.
REQ-013 flags_fwd  out  4  combinational, newest flags visible to the same-cycle branch resolver.

Function
REQ-014 Update priority per edge SHALL be reset > flush > stall > load.
REQ-015 Load (flush=0, stall=0): every *_MEM output SHALL equal its *_EX/ALU input one edge later; latency 1 cycle.
REQ-016 Flush: valid_MEM, memToReg_MEM, memWrite_MEM, memRead_MEM, branchLink_MEM, RegWrite_MEM SHALL clear to 0; targetReg_MEM to 5'd31; 64-bit fields to 0.
REQ-017 Stall without flush: all *_MEM outputs and flags SHALL hold.
REQ-018 Flush together with stall: flush wins; a bubble is inserted.
REQ-019 A flags write occurs only when set_flags_EX=1, valid_EX=1, stall=0, flush=0.
REQ-020 flags_fwd SHALL equal alu_flags when a flags write occurs this cycle, else flags.
REQ-021 An input with valid_EX=0 SHALL load as a bubble (REQ-016 values) even when flush=0.
REQ-022 No memory or register side-effect control bit SHALL ever be 1 while valid_MEM=0.

Reset
REQ-023 While reset=0, all *_MEM outputs SHALL take bubble values (REQ-016), and flags SHALL be 4'b0000, asynchronously.
REQ-024 Reset deassertion mid-stream: the first edge after release SHALL follow REQ-014 normally; no instruction is captured while reset=0.

Configuration
REQ-025 Macro EX_MEM_PERF_CNT_EN: when defined, outputs stall_cnt and bubble_cnt (32 bits each) SHALL exist.
REQ-026 stall_cnt SHALL increment on each edge with stall=1 and flush=0.
REQ-027 bubble_cnt SHALL increment on each edge that loads a bubble via REQ-016 or REQ-021.
REQ-028 Both counters SHALL saturate at 32'hFFFF_FFFF and clear on reset.
REQ-029 When the macro is undefined, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 Shared package ex_mem_pkg SHALL hold the payload struct type ex_mem_t (the control bits, targetReg, and the three 64-bit fields), the constant EX_MEM_BUBBLE, the NZCV bit-index constants, and the constant XZR_IDX=5'd31.
REQ-031 Sub-module ex_mem_flag_reg SHALL implement the NZCV register, its write-enable, and flags_fwd; the top SHALL instantiate it once.

Verification
REQ-032 Load: alu_result=64'd300, rd2_EX=64'd40, targetReg_EX=5'd20, RegWrite_EX=1, valid_EX=1 -> one edge later alu_result_MEM=300, rd2_MEM=40, targetReg_MEM=20, RegWrite_MEM=1, valid_MEM=1.
REQ-033 Stall: load alu_result=64'd5, then hold stall=1 for 3 edges while alu_result=64'd9 -> alu_result_MEM stays 5 through those edges and becomes 9 on the first edge with stall=0; stall_cnt=3 if enabled.
REQ-034 Flush+stall: memWrite_EX=1, valid_EX=1, stall=1, flush=1 -> memWrite_MEM=0, valid_MEM=0, targetReg_MEM=31, bubble_cnt increments by 1.
REQ-035 Flags: set_flags_EX=1, valid_EX=1, alu_flags=4'b0100 -> flags_fwd=4'b0100 in the same cycle, flags=4'b0100 after the edge; repeat with stall=1 and alu_flags=4'b1000 -> flags stays 4'b0100, flags_fwd=4'b0100.
REQ-036 Async reset: assert reset=0 between edges while valid_MEM=1 and flags=4'b0110 -> immediately valid_MEM=0, flags=0, and all counters=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg -- shared types and constants for the EX/MEM pipeline stage.
//   ex_mem_t      : registered EX/MEM payload (control bits, target register,
//                   ALU result, store data, link value)
//   EX_MEM_BUBBLE : payload of an empty slot (all control 0, target XZR, data 0)
//   FLAG_N/Z/C/V  : bit positions inside a 4-bit NZCV vector
//   XZR_IDX       : register index of the zero register
package ex_mem_pkg;

  localparam logic [4:0] XZR_IDX = 5'd31;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef struct packed {
    logic        valid;
    logic        mem_to_reg;
    logic        mem_write;
    logic        mem_read;
    logic        branch_link;
    logic        reg_write;
    logic [4:0]  target_reg;
    logic [63:0] alu_result;
    logic [63:0] rd2;
    logic [63:0] pc_plus4;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '{
    valid:       1'b0,
    mem_to_reg:  1'b0,
    mem_write:   1'b0,
    mem_read:    1'b0,
    branch_link: 1'b0,
    reg_write:   1'b0,
    target_reg:  XZR_IDX,
    alu_result:  64'd0,
    rd2:         64'd0,
    pc_plus4:    64'd0
  };

  // What the stage register does on a given edge.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_LOAD,
    UPD_BUBBLE
  } ex_mem_upd_e;

endpackage

// File: rtl/ex_mem_flag_reg.sv
// ex_mem_flag_reg -- architectural NZCV register with same-cycle forwarding.
// Ports:
//   clk        in   pipeline clock, state captured on the falling edge
//   reset      in   asynchronous active-low, clears flags to 0
//   set_flags  in   instruction in EX wants to write flags
//   valid      in   instruction in EX is real (not a bubble)
//   stall      in   stage held this cycle
//   flush      in   instruction in EX is being squashed
//   alu_flags  in   NZCV from the ALU (bit3=N .. bit0=V)
//   flags      out  architectural NZCV register
//   flags_fwd  out  newest flags: alu_flags when written this cycle, else flags
module ex_mem_flag_reg
  import ex_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_flags,
  input  logic       valid,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags,
  output logic [3:0] flags_fwd
);

  logic flags_we;

  always_comb begin
    flags_we  = set_flags && valid && !stall && !flush;
    flags_fwd = flags_we ? alu_flags : flags;
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (flags_we) begin
      flags <= alu_flags;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- EX/MEM pipeline register with NZCV flag register.
// Edge priority: reset > flush > stall > load. An incoming instruction with
// valid_EX=0 loads as a bubble. All state captures on the falling clock edge.
// Ports:
//   clk, reset (async active-low), stall, flush
//   *_EX control bits, targetReg_EX, alu_result, rd2_EX, pc_plus4_EX, alu_flags
//   *_MEM registered control/data, flags (NZCV), flags_fwd (combinational)
// Optional (macro EX_MEM_PERF_CNT_EN): stall_cnt, bubble_cnt, 32-bit saturating.
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_EX,
  input  logic        memToReg_EX,
  input  logic        memWrite_EX,
  input  logic        memRead_EX,
  input  logic        branchLink_EX,
  input  logic        RegWrite_EX,
  input  logic        set_flags_EX,
  input  logic [4:0]  targetReg_EX,
  input  logic [63:0] alu_result,
  input  logic [63:0] rd2_EX,
  input  logic [63:0] pc_plus4_EX,
  input  logic [3:0]  alu_flags,
  output logic        valid_MEM,
  output logic        memToReg_MEM,
  output logic        memWrite_MEM,
  output logic        memRead_MEM,
  output logic        branchLink_MEM,
  output logic        RegWrite_MEM,
  output logic [4:0]  targetReg_MEM,
  output logic [63:0] alu_result_MEM,
  output logic [63:0] rd2_MEM,
  output logic [63:0] pc_plus4_MEM,
  output logic [3:0]  flags,
  output logic [3:0]  flags_fwd
`ifdef EX_MEM_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  ex_mem_t     ex_in;
  ex_mem_t     mem_q;
  ex_mem_upd_e upd;

  always_comb begin
    ex_in = '{
      valid:       valid_EX,
      mem_to_reg:  memToReg_EX,
      mem_write:   memWrite_EX,
      mem_read:    memRead_EX,
      branch_link: branchLink_EX,
      reg_write:   RegWrite_EX,
      target_reg:  targetReg_EX,
      alu_result:  alu_result,
      rd2:         rd2_EX,
      pc_plus4:    pc_plus4_EX
    };

    // Invalid instructions become bubbles so side-effect bits never reach MEM
    // without valid set.
    upd = UPD_LOAD;
    if (flush) begin
      upd = UPD_BUBBLE;
    end else if (stall) begin
      upd = UPD_HOLD;
    end else if (!valid_EX) begin
      upd = UPD_BUBBLE;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= EX_MEM_BUBBLE;
    end else begin
      case (upd)
        UPD_LOAD:   mem_q <= ex_in;
        UPD_BUBBLE: mem_q <= EX_MEM_BUBBLE;
        default:    mem_q <= mem_q;
      endcase
    end
  end

  assign valid_MEM      = mem_q.valid;
  assign memToReg_MEM   = mem_q.mem_to_reg;
  assign memWrite_MEM   = mem_q.mem_write;
  assign memRead_MEM    = mem_q.mem_read;
  assign branchLink_MEM = mem_q.branch_link;
  assign RegWrite_MEM   = mem_q.reg_write;
  assign targetReg_MEM  = mem_q.target_reg;
  assign alu_result_MEM = mem_q.alu_result;
  assign rd2_MEM        = mem_q.rd2;
  assign pc_plus4_MEM   = mem_q.pc_plus4;

  ex_mem_flag_reg u_flag_reg (
    .clk       (clk),
    .reset     (reset),
    .set_flags (set_flags_EX),
    .valid     (valid_EX),
    .stall     (stall),
    .flush     (flush),
    .alu_flags (alu_flags),
    .flags     (flags),
    .flags_fwd (flags_fwd)
  );

`ifdef EX_MEM_PERF_CNT_EN
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (upd == UPD_HOLD && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (upd == UPD_BUBBLE && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
